ibr128_axi_cmd_master: RTL and testbench

- Upstream AXI4 master that feeds the AXI4-to-IBR128 top-level slave.
- Accepts one 128-bit cipher command (key, data block, direction) on a valid/ready port.
- Runs the IBR128 register sequence as single-beat AXI4 transactions: load key/data, start, poll status, read result.
- Returns the 128-bit result, or an error flag, on a valid/ready response port.

---
 rtl/ibr128_axi_cmd_master.sv | 328 ++++++++++++++++++++++++++++++++
 tb/tb_ibr128_axi_cmd_master.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibr128_axi_cmd_master.sv
// AXI4 master that drives one IBR128 cipher command through the slave's register window.
// Optional key cache when IBR128_KEY_CACHE_EN is defined: repeated keys skip the key writes.
module ibr128_axi_cmd_master #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [7:0]  AXI_ID    = 8'h00,
    parameter int unsigned POLL_MAX  = 1024
) (
    input  logic         axi_aclk,
    input  logic         axi_areset,

    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [127:0] cmd_key,
    input  logic [127:0] cmd_data,
    input  logic         cmd_decrypt,

    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_data,
    output logic         rsp_error,

    output logic [7:0]   m_axi_awid,
    output logic [31:0]  m_axi_awaddr,
    output logic [7:0]   m_axi_awlen,
    output logic [2:0]   m_axi_awsize,
    output logic [1:0]   m_axi_awburst,
    output logic [1:0]   m_axi_awlock,
    output logic [3:0]   m_axi_awcache,
    output logic [2:0]   m_axi_awprot,
    output logic [3:0]   m_axi_awqos,
    output logic         m_axi_awvalid,
    input  logic         m_axi_awready,

    output logic [31:0]  m_axi_wdata,
    output logic [3:0]   m_axi_wstrb,
    output logic         m_axi_wlast,
    output logic         m_axi_wvalid,
    input  logic         m_axi_wready,

    input  logic [7:0]   m_axi_bid,
    input  logic [1:0]   m_axi_bresp,
    input  logic         m_axi_bvalid,
    output logic         m_axi_bready,

    output logic [7:0]   m_axi_arid,
    output logic [31:0]  m_axi_araddr,
    output logic [7:0]   m_axi_arlen,
    output logic [2:0]   m_axi_arsize,
    output logic [1:0]   m_axi_arburst,
    output logic [1:0]   m_axi_arlock,
    output logic [3:0]   m_axi_arcache,
    output logic [2:0]   m_axi_arprot,
    output logic [3:0]   m_axi_arqos,
    output logic         m_axi_arvalid,
    input  logic         m_axi_arready,

    input  logic [7:0]   m_axi_rid,
    input  logic [31:0]  m_axi_rdata,
    input  logic [1:0]   m_axi_rresp,
    input  logic         m_axi_rlast,
    input  logic         m_axi_rvalid,
    output logic         m_axi_rready
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_RESP,
        S_STAT_AR,
        S_STAT_R,
        S_OUT_AR,
        S_OUT_R,
        S_ERR,
        S_RESP
    } state_t;

    localparam logic [15:0] POLL_LIMIT = POLL_MAX[15:0];
    localparam logic [3:0]  IDX_DIN    = 4'd4;
    localparam logic [3:0]  IDX_CTRL   = 4'd8;
    localparam logic [3:0]  IDX_STATUS = 4'd9;
    localparam logic [3:0]  IDX_DOUT0  = 4'd10;
    localparam logic [3:0]  IDX_DOUT3  = 4'd13;

    state_t         state_q, state_d;
    logic [3:0]     idx_q, idx_d;
    logic [15:0]    poll_q, poll_d;
    logic [127:0]   key_q, key_d;
    logic [127:0]   data_q, data_d;
    logic           dec_q, dec_d;
    logic           aw_done_q, aw_done_d;
    logic           w_done_q, w_done_d;
    logic [127:0]   rsp_data_q, rsp_data_d;
    logic           rsp_err_q, rsp_err_d;

    logic           key_hit;
    logic           b_ok;
    logic           r_ok;
    logic [31:0]    wdata_w;
    logic [3:0]     out_off;
    logic           unused_rlast;

`ifdef IBR128_KEY_CACHE_EN
    logic [127:0]   cache_key_q, cache_key_d;
    logic           key_valid_q, key_valid_d;

    assign key_hit = key_valid_q && (cmd_key == cache_key_q);
`else
    assign key_hit = 1'b0;
`endif

    assign unused_rlast = m_axi_rlast;

    assign b_ok    = (m_axi_bresp == 2'b00) && (m_axi_bid == AXI_ID);
    assign r_ok    = (m_axi_rresp == 2'b00) && (m_axi_rid == AXI_ID);
    assign out_off = idx_q - IDX_DOUT0;

    // Reset gates cmd_ready so no command can be taken while reset is held.
    assign cmd_ready = (state_q == S_IDLE) && !axi_areset;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_error = rsp_err_q;

    assign m_axi_awid    = AXI_ID;
    assign m_axi_awaddr  = BASE_ADDR + {26'd0, idx_q, 2'b00};
    assign m_axi_awlen   = 8'd0;
    assign m_axi_awsize  = 3'd2;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 2'b00;
    assign m_axi_awcache = 4'd0;
    assign m_axi_awprot  = 3'd0;
    assign m_axi_awqos   = 4'd0;
    assign m_axi_awvalid = (state_q == S_WR_ADDR) && !aw_done_q;

    assign m_axi_wdata   = wdata_w;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wlast   = 1'b1;
    assign m_axi_wvalid  = (state_q == S_WR_ADDR) && !w_done_q;

    assign m_axi_bready  = (state_q == S_WR_RESP);

    assign m_axi_arid    = AXI_ID;
    assign m_axi_araddr  = BASE_ADDR + {26'd0, idx_q, 2'b00};
    assign m_axi_arlen   = 8'd0;
    assign m_axi_arsize  = 3'd2;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 2'b00;
    assign m_axi_arcache = 4'd0;
    assign m_axi_arprot  = 3'd0;
    assign m_axi_arqos   = 4'd0;
    assign m_axi_arvalid = (state_q == S_STAT_AR) || (state_q == S_OUT_AR);
    assign m_axi_rready  = (state_q == S_STAT_R) || (state_q == S_OUT_R);

    // Write data follows idx: key words, then data words, then the CTRL value.
    always_comb begin
        wdata_w = {30'd0, dec_q, 1'b1};
        if (idx_q < IDX_DIN) begin
            wdata_w = key_q[{idx_q[1:0], 5'd0} +: 32];
        end else if (idx_q < IDX_CTRL) begin
            wdata_w = data_q[{idx_q[1:0], 5'd0} +: 32];
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        poll_d     = poll_q;
        key_d      = key_q;
        data_d     = data_q;
        dec_d      = dec_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
`ifdef IBR128_KEY_CACHE_EN
        cache_key_d = cache_key_q;
        key_valid_d = key_valid_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    key_d     = cmd_key;
                    data_d    = cmd_data;
                    dec_d     = cmd_decrypt;
                    idx_d     = key_hit ? IDX_DIN : 4'd0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = S_WR_ADDR;
                end
            end

            S_WR_ADDR: begin
                aw_done_d = aw_done_q || m_axi_awready;
                w_done_d  = w_done_q || m_axi_wready;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = S_WR_RESP;
                end
            end

            S_WR_RESP: begin
                if (m_axi_bvalid) begin
                    if (!b_ok) begin
                        state_d = S_ERR;
                    end else if (idx_q == IDX_CTRL) begin
                        idx_d   = IDX_STATUS;
                        poll_d  = 16'd0;
                        state_d = S_STAT_AR;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_WR_ADDR;
                    end
                end
            end

            S_STAT_AR: begin
                if (m_axi_arready) begin
                    state_d = S_STAT_R;
                end
            end

            S_STAT_R: begin
                if (m_axi_rvalid) begin
                    if (!r_ok) begin
                        state_d = S_ERR;
                    end else if (m_axi_rdata[0]) begin
                        idx_d   = IDX_DOUT0;
                        state_d = S_OUT_AR;
                    end else if (poll_q + 16'd1 == POLL_LIMIT) begin
                        state_d = S_ERR;
                    end else begin
                        poll_d  = poll_q + 16'd1;
                        state_d = S_STAT_AR;
                    end
                end
            end

            S_OUT_AR: begin
                if (m_axi_arready) begin
                    state_d = S_OUT_R;
                end
            end

            S_OUT_R: begin
                if (m_axi_rvalid) begin
                    if (!r_ok) begin
                        state_d = S_ERR;
                    end else begin
                        rsp_data_d[{out_off[1:0], 5'd0} +: 32] = m_axi_rdata;
                        if (idx_q == IDX_DOUT3) begin
                            state_d = S_RESP;
                        end else begin
                            idx_d   = idx_q + 4'd1;
                            state_d = S_OUT_AR;
                        end
                    end
                end
            end

            S_ERR: begin
                rsp_data_d = '0;
                rsp_err_d  = 1'b1;
`ifdef IBR128_KEY_CACHE_EN
                key_valid_d = 1'b0;
`endif
                state_d    = S_RESP;
            end

            S_RESP: begin
                if (rsp_ready) begin
`ifdef IBR128_KEY_CACHE_EN
                    // Only a key that was proven good by a clean completion is cached.
                    if (!rsp_err_q) begin
                        cache_key_d = key_q;
                        key_valid_d = 1'b1;
                    end
`endif
                    rsp_err_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            state_q    <= S_IDLE;
            idx_q      <= 4'd0;
            poll_q     <= 16'd0;
            key_q      <= '0;
            data_q     <= '0;
            dec_q      <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            poll_q     <= poll_d;
            key_q      <= key_d;
            data_q     <= data_d;
            dec_q      <= dec_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

`ifdef IBR128_KEY_CACHE_EN
    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            cache_key_q <= '0;
            key_valid_q <= 1'b0;
        end else begin
            cache_key_q <= cache_key_d;
            key_valid_q <= key_valid_d;
        end
    end
`endif

endmodule

// File: tb/tb_ibr128_axi_cmd_master.sv
// Scoreboard bench: two masters (POLL_MAX 1024 and 4) share one reactive IBR128 slave model.
module tb_ibr128_axi_cmd_master;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam logic [7:0]  ID   = 8'h3C;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         axi_areset;
    logic         sel;
    logic [1:0]   cmd_valid_x;
    logic [127:0] cmd_key, cmd_data;
    logic         cmd_decrypt;
    logic         rsp_ready;

    logic [1:0]         cmd_ready_x, rsp_valid_x, rsp_error_x;
    logic [1:0][127:0]  rsp_data_x;
    logic [1:0][7:0]    awid_x, awlen_x, arid_x, arlen_x;
    logic [1:0][31:0]   awaddr_x, wdata_x, araddr_x;
    logic [1:0][2:0]    awsize_x, awprot_x, arsize_x, arprot_x;
    logic [1:0][1:0]    awburst_x, awlock_x, arburst_x, arlock_x;
    logic [1:0][3:0]    awcache_x, awqos_x, wstrb_x, arcache_x, arqos_x;
    logic [1:0]         awvalid_x, wlast_x, wvalid_x, bready_x, arvalid_x, rready_x;

    logic         awready_r, arready_r, wready_rnd, s_wready;
    logic         bvalid_r, rvalid_r;
    logic [1:0]   bresp_r;
    logic [7:0]   bid_r, rid_r;
    logic [31:0]  rdata_r;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        ibr128_axi_cmd_master #(
            .BASE_ADDR(BASE), .AXI_ID(ID), .POLL_MAX(gi == 0 ? 1024 : 4)
        ) u_dut (
            .axi_aclk(clk), .axi_areset(axi_areset),
            .cmd_valid(cmd_valid_x[gi]), .cmd_ready(cmd_ready_x[gi]),
            .cmd_key(cmd_key), .cmd_data(cmd_data), .cmd_decrypt(cmd_decrypt),
            .rsp_valid(rsp_valid_x[gi]), .rsp_ready(rsp_ready),
            .rsp_data(rsp_data_x[gi]), .rsp_error(rsp_error_x[gi]),
            .m_axi_awid(awid_x[gi]), .m_axi_awaddr(awaddr_x[gi]), .m_axi_awlen(awlen_x[gi]),
            .m_axi_awsize(awsize_x[gi]), .m_axi_awburst(awburst_x[gi]), .m_axi_awlock(awlock_x[gi]),
            .m_axi_awcache(awcache_x[gi]), .m_axi_awprot(awprot_x[gi]), .m_axi_awqos(awqos_x[gi]),
            .m_axi_awvalid(awvalid_x[gi]), .m_axi_awready(awready_r),
            .m_axi_wdata(wdata_x[gi]), .m_axi_wstrb(wstrb_x[gi]), .m_axi_wlast(wlast_x[gi]),
            .m_axi_wvalid(wvalid_x[gi]), .m_axi_wready(s_wready),
            .m_axi_bid(bid_r), .m_axi_bresp(bresp_r), .m_axi_bvalid(bvalid_r), .m_axi_bready(bready_x[gi]),
            .m_axi_arid(arid_x[gi]), .m_axi_araddr(araddr_x[gi]), .m_axi_arlen(arlen_x[gi]),
            .m_axi_arsize(arsize_x[gi]), .m_axi_arburst(arburst_x[gi]), .m_axi_arlock(arlock_x[gi]),
            .m_axi_arcache(arcache_x[gi]), .m_axi_arprot(arprot_x[gi]), .m_axi_arqos(arqos_x[gi]),
            .m_axi_arvalid(arvalid_x[gi]), .m_axi_arready(arready_r),
            .m_axi_rid(rid_r), .m_axi_rdata(rdata_r), .m_axi_rresp(2'b00), .m_axi_rlast(1'b1),
            .m_axi_rvalid(rvalid_r), .m_axi_rready(rready_x[gi])
        );
    end

    // Active master's outputs, as seen by the slave model.
    logic         s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
    logic [31:0]  s_awaddr, s_wdata, s_araddr;
    logic [7:0]   s_awid, s_arid;
    logic         rsp_valid_m, rsp_error_m;
    logic [127:0] rsp_data_m;
    assign s_awvalid   = awvalid_x[sel];
    assign s_wvalid    = wvalid_x[sel];
    assign s_bready    = bready_x[sel];
    assign s_arvalid   = arvalid_x[sel];
    assign s_rready    = rready_x[sel];
    assign s_awaddr    = awaddr_x[sel];
    assign s_wdata     = wdata_x[sel];
    assign s_araddr    = araddr_x[sel];
    assign s_awid      = awid_x[sel];
    assign s_arid      = arid_x[sel];
    assign rsp_valid_m = rsp_valid_x[sel];
    assign rsp_error_m = rsp_error_x[sel];
    assign rsp_data_m  = rsp_data_x[sel];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    logic [63:0]  exp_wr_q[$];
    logic [128:0] exp_rsp_q[$];

    bit           stall_en = 1'b0;
    int           err_at   = -1;
    int           done_at  = 1;
    logic [31:0]  dout [4];

    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, wr_total = 0, stat_total = 0;
    int viol_stab = 0, viol_ovl = 0;
    logic         aw_seen, w_seen, outst;
    logic         st_aw, st_w, st_ar;
    logic [31:0]  st_awaddr, st_wdata, st_araddr, aw_addr_l, w_data_l, last_ar;
    logic [31:0]  wa, wd, roff;
    logic         aw_hs, w_hs, ar_hs, b_hs, r_hs;

    assign s_wready = stall_en ? (wready_rnd && aw_seen) : 1'b1;
    assign aw_hs    = s_awvalid && awready_r;
    assign w_hs     = s_wvalid && s_wready;
    assign ar_hs    = s_arvalid && arready_r;
    assign b_hs     = bvalid_r && s_bready;
    assign r_hs     = rvalid_r && s_rready;

    always @(posedge clk) begin
        if (axi_areset) begin
            awready_r <= 1'b1; arready_r <= 1'b1; wready_rnd <= 1'b1;
            bvalid_r <= 1'b0; rvalid_r <= 1'b0; aw_seen <= 1'b0; w_seen <= 1'b0;
            outst <= 1'b0; st_aw <= 1'b0; st_w <= 1'b0; st_ar <= 1'b0;
            bresp_r <= 2'b00; bid_r <= 8'd0; rid_r <= 8'd0; rdata_r <= 32'd0;
        end else begin
            awready_r  <= stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            arready_r  <= stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            wready_rnd <= 1'($urandom_range(0, 1));

            if ((st_aw && (!s_awvalid || s_awaddr != st_awaddr)) ||
                (st_w && (!s_wvalid || s_wdata != st_wdata)) ||
                (st_ar && (!s_arvalid || s_araddr != st_araddr)))
                viol_stab <= viol_stab + 1;
            st_aw <= s_awvalid && !awready_r;  st_awaddr <= s_awaddr;
            st_w  <= s_wvalid && !s_wready;    st_wdata  <= s_wdata;
            st_ar <= s_arvalid && !arready_r;  st_araddr <= s_araddr;

            if (((s_awvalid || s_arvalid) && outst) || (s_awvalid && s_arvalid))
                viol_ovl <= viol_ovl + 1;
            if (aw_hs || ar_hs) outst <= 1'b1;
            if (b_hs || r_hs) outst <= 1'b0;

            if (aw_hs) begin
                aw_cnt <= aw_cnt + 1; aw_seen <= 1'b1; aw_addr_l <= s_awaddr; bid_r <= s_awid;
            end
            if (w_hs) begin
                w_cnt <= w_cnt + 1; w_seen <= 1'b1; w_data_l <= s_wdata;
            end
            if ((aw_seen || aw_hs) && (w_seen || w_hs)) begin
                wa = aw_hs ? s_awaddr : aw_addr_l;
                wd = w_hs ? s_wdata : w_data_l;
                if (exp_wr_q.size() == 0) begin
                    check("wr_unexpected", 160'(exp_wr_q.size()), 160'd1);
                end else begin
                    check("wr_addr_data", {wa, wd}, exp_wr_q.pop_front());
                end
                bvalid_r <= 1'b1;
                bresp_r  <= (wr_total + 1 == err_at) ? 2'b10 : 2'b00;
                wr_total <= wr_total + 1;
                aw_seen  <= 1'b0;
                w_seen   <= 1'b0;
            end
            if (b_hs) bvalid_r <= 1'b0;

            if (ar_hs) begin
                ar_cnt   <= ar_cnt + 1;
                last_ar  <= s_araddr;
                rvalid_r <= 1'b1;
                rid_r    <= s_arid;
                roff     = s_araddr - BASE - 32'h28;
                if (s_araddr == BASE + 32'h24) begin
                    stat_total <= stat_total + 1;
                    rdata_r    <= {31'd0, (stat_total + 1 >= done_at)};
                end else if (roff < 32'd16) begin
                    rdata_r <= dout[roff[3:2]];
                end else begin
                    rdata_r <= 32'hDEAD_BEEF;
                end
            end
            if (r_hs) rvalid_r <= 1'b0;
        end
    end

    bit           kv [2];
    logic [127:0] kc [2];
    int           exp_nwr, cur_sel, cmd_no = 0;
    logic [127:0] cur_key;
    int           wr0, aw0, w0, ar0, st0, lat;

    task automatic send_cmd(input int s, input logic [127:0] key, input logic [127:0] data,
                            input logic dec, input logic err);
        int start = 0;
        int t = 0;
`ifdef IBR128_KEY_CACHE_EN
        if (kv[s] && kc[s] == key) start = 4;
`endif
        exp_nwr = 9 - start;
        for (int i = start; i < 8; i++)
            exp_wr_q.push_back({BASE + 32'(4 * i), (i < 4) ? key[32 * i +: 32] : data[32 * (i - 4) +: 32]});
        exp_wr_q.push_back({BASE + 32'h20, 30'd0, dec, 1'b1});
        exp_rsp_q.push_back({err, err ? 128'd0 : {dout[3], dout[2], dout[1], dout[0]}});
        wr0 = wr_total; aw0 = aw_cnt; w0 = w_cnt; ar0 = ar_cnt; st0 = stat_total;
        cur_sel = s; cur_key = key;
        sel = s[0]; cmd_key = key; cmd_data = data; cmd_decrypt = dec;
        cmd_valid_x[s] = 1'b1;
        while (!cmd_ready_x[s] && t < 50) begin @(posedge clk); #1; t++; end
        check("cmd_ready", 160'(cmd_ready_x[s]), 160'd1);
        @(posedge clk); #1;
        cmd_valid_x = 2'b00;
        // Scramble the command inputs: the master must be using its latched copy.
        cmd_key = ~key; cmd_data = ~data; cmd_decrypt = ~dec;
    endtask

    task automatic get_rsp(input int hold, output int latency);
        int t = 0;
        logic [128:0] e = '0;
        rsp_ready = 1'b0;
        while (!rsp_valid_m && t < 4000) begin @(posedge clk); #1; t++; end
        latency = t;
        check("rsp_valid_seen", 160'(rsp_valid_m), 160'd1);
        if (exp_rsp_q.size() == 0) check("rsp_unexpected", 160'(exp_rsp_q.size()), 160'd1);
        else e = exp_rsp_q.pop_front();
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", 160'(rsp_valid_m), 160'd1);
            check("hold_payload", {rsp_error_m, rsp_data_m}, 160'(e));
            @(posedge clk); #1;
        end
        check("rsp_data", rsp_data_m, e[127:0]);
        check("rsp_error", 160'(rsp_error_m), 160'(e[128]));
        $display("cmd %0d: sel=%0d data=%h err=%b latency=%0d", cmd_no, cur_sel, rsp_data_m, rsp_error_m, t);
        cmd_no++;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rsp_released", {rsp_valid_m, rsp_error_m}, 160'd0);
        kv[cur_sel] = !e[128];
        kc[cur_sel] = cur_key;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not complete");
    end

    initial begin
        int t;
        bit seen;
        axi_areset = 1'b1; sel = 1'b0; cmd_valid_x = 2'b00; rsp_ready = 1'b0;
        cmd_key = '0; cmd_data = '0; cmd_decrypt = 1'b0;
        dout[0] = 32'hA; dout[1] = 32'hB; dout[2] = 32'hC; dout[3] = 32'hD;
        kv[0] = 1'b0; kv[1] = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready_low", 160'(cmd_ready_x), 160'd0);
        check("rst_valids", {awvalid_x, wvalid_x, arvalid_x, rsp_valid_x, bready_x, rready_x}, 160'd0);
        check("rst_rsp", {rsp_error_x, rsp_data_x[0], rsp_data_x[1]}, 160'd0);
        axi_areset = 1'b0;
        @(posedge clk); #1;
        check("idle_cmd_ready", 160'(cmd_ready_x), 160'd3);
        check("aw_const", {awid_x[0], awlen_x[0], awsize_x[0], awburst_x[0], awlock_x[0], awcache_x[0],
                           awprot_x[0], awqos_x[0], wstrb_x[0], wlast_x[0]},
              {ID, 8'd0, 3'd2, 2'b01, 2'b00, 4'd0, 3'd0, 4'd0, 4'hF, 1'b1});
        check("ar_const", {arid_x[0], arlen_x[0], arsize_x[0], arburst_x[0], arlock_x[0], arcache_x[0],
                           arprot_x[0], arqos_x[0]},
              {ID, 8'd0, 3'd2, 2'b01, 2'b00, 4'd0, 3'd0, 4'd0});

        // Zero-wait encrypt: response in cycle 30 counting the accept cycle as 1.
        send_cmd(0, 128'h0, 128'h1, 1'b0, 1'b0);
        get_rsp(0, lat);
        check("latency_edges", 160'(lat), 160'd28);
        check("t1_writes", 160'(wr_total - wr0), 160'(exp_nwr));
        check("t1_stat_reads", 160'(stat_total - st0), 160'd1);

        // Decrypt under random stalls, W always held back until AW is taken.
        stall_en = 1'b1;
        send_cmd(0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 128'hCAFE_F00D_0000_1111_2222_3333_4444_5555,
                 1'b1, 1'b0);
        get_rsp(0, lat);
        stall_en = 1'b0;
        check("t2_aw_count", 160'(aw_cnt - aw0), 160'(exp_nwr));
        check("t2_w_count", 160'(w_cnt - w0), 160'(exp_nwr));
        check("t2_reads", 160'(ar_cnt - ar0), 160'd5);

        // Done only on the fifth status read.
        done_at = stat_total + 5;
        send_cmd(0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 128'h5A5A_A5A5_0F0F_F0F0_1234_5678_9ABC_DEF0,
                 1'b0, 1'b0);
        get_rsp(0, lat);
        check("t3_stat_reads", 160'(stat_total - st0), 160'd5);

        // Done never set on the POLL_MAX=4 master.
        done_at = 32'h7FFF_FFFF;
        send_cmd(1, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 128'h9, 1'b0, 1'b1);
        get_rsp(0, lat);
        check("t4_stat_reads", 160'(stat_total - st0), 160'd4);
        check("t4_reads", 160'(ar_cnt - ar0), 160'd4);
        done_at = 1;

        // SLVERR on the third write, response held off for 10 cycles.
        err_at = wr_total + 3;
        send_cmd(0, 128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000_1234, 128'h77, 1'b0, 1'b1);
        get_rsp(10, lat);
        check("t5_aw_after_err", 160'(aw_cnt - aw0), 160'd3);
        check("t5_ar_after_err", 160'(ar_cnt - ar0), 160'd0);
        check("t5_pending_writes", 160'(exp_wr_q.size()), 160'(exp_nwr - 3));
        exp_wr_q.delete();
        err_at = -1;

        // Reset while reading DOUT word 1: the command is dropped silently.
        send_cmd(0, 128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000_1234, 128'h88, 1'b0, 1'b0);
        t = 0;
        while (last_ar != BASE + 32'h2C && t < 500) begin @(posedge clk); #1; t++; end
        check("t6_in_rd_out", 160'(last_ar), 160'(BASE + 32'h2C));
        axi_areset = 1'b1;
        @(posedge clk); #1;
        check("t6_valids_drop", {awvalid_x[0], wvalid_x[0], arvalid_x[0], rready_x[0], bready_x[0]}, 160'd0);
        @(posedge clk); #1;
        axi_areset = 1'b0;
        void'(exp_rsp_q.pop_back());
        kv[0] = 1'b0; kv[1] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            seen = seen | rsp_valid_x[0];
            @(posedge clk); #1;
        end
        check("t6_no_rsp", 160'(seen), 160'd0);
        check("t6_cmd_ready", 160'(cmd_ready_x[0]), 160'd1);

        for (int i = 0; i < 4; i++) dout[i] = $urandom;
        send_cmd(0, 128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000_1234, 128'h99, 1'b0, 1'b0);
        get_rsp(0, lat);
        check("t7_writes", 160'(wr_total - wr0), 160'd9);

        // Same key again, then a new key.
        send_cmd(0, 128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000_1234, 128'hABCD, 1'b1, 1'b0);
        get_rsp(0, lat);
        check("t8_writes", 160'(wr_total - wr0), 160'(exp_nwr));
`ifdef IBR128_KEY_CACHE_EN
        check("t8_cache_hit_writes", 160'(wr_total - wr0), 160'd5);
`endif
        send_cmd(0, 128'h5555_4444_3333_2222_1111_0000_9999_8888, 128'h1234, 1'b0, 1'b0);
        get_rsp(0, lat);
        check("t9_writes", 160'(wr_total - wr0), 160'd9);

        check("exp_writes_drained", 160'(exp_wr_q.size()), 160'd0);
        check("axi_stable_while_stalled", 160'(viol_stab), 160'd0);
        check("single_outstanding", 160'(viol_ovl), 160'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
